ex_alu_arbiter: RTL
===================

Name: ex_alu_arbiter

Overview:
- Shares one integer ALU among NREQ issue requesters, such as reservation-station entries.
- Arbitrates round-robin, executes the granted op and registers the result with its tag.
- Presents the result to the common data bus through a valid/ready handshake.
- Sits between the reservation stations and the CDB arbiter in the EX stage.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width
OP_W, 5, ALU op-code width (ALU_* encodings from define.h)
TAG_W, 4, ROB/RS tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush; drops the held result, blocks grants this cycle
req_valid  in  NREQ  per-requester op valid
req_op  in  NREQ*OP_W  op code; requester i at [i*OP_W +: OP_W]
req_src1  in  NREQ*DATA_W  operand 1 (shift amount in bits [4:0]); same packing
req_src2  in  NREQ*DATA_W  operand 2 (shifted value); same packing
req_tag  in  NREQ*TAG_W  destination tag; same packing
req_ready  out  NREQ  one-hot grant; op i consumed on a cycle with req_valid[i] and req_ready[i]
out_valid  out  1  result held for the CDB
out_ready  in  1  CDB accepts the result
out_result  out  DATA_W  ALU result
out_tag  out  TAG_W  tag of the result
out_src  out  clog2(NREQ)  index of the requester that produced the result

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_result=0, out_tag=0, out_src=0, rr_ptr=0.
  - req_ready is forced to 0 while rst is high.
- accept = !out_valid || out_ready.
- Grant (combinational):
  - Only when accept && !flush && !rst.
  - Winner: first i with req_valid[i], searching cyclically from rr_ptr.
  - req_ready[winner]=1; all other bits 0.
  - No valid requester: req_ready=0.
  - req_ready never depends on out_valid alone when out_ready=1 (pass-through accept).
- Round-robin pointer:
  - On a grant to index g: rr_ptr <= (g+1) mod NREQ.
  - No grant: rr_ptr holds.
  - Fairness: a continuously valid requester is granted within NREQ grants.
- Execute: the granted op is computed combinationally, and at the same edge:
  - out_result/out_tag/out_src are loaded and out_valid <= 1.
  - Latency: 1 cycle from grant to out_valid.
- Drain: out_valid && out_ready && no new grant -> out_valid <= 0; data regs hold their last value.
- Back-to-back:
  - out_valid && out_ready && a grant -> new result loads.
  - out_valid stays 1, giving 1 result/cycle throughput.
- Stall: out_valid && !out_ready -> all out_* hold stable and req_ready=0.
- Flush:
  - out_valid <= 0 regardless of out_ready.
  - No grant that cycle; rr_ptr holds.
  - flush together with rst: rst wins (same end state).
- ALU ops, on DATA_W bits with wrap-around; shift amount sh = src1[4:0]:
  - ADD/ADDU = src1+src2; SUB/SUBU = src1-src2 (no overflow trap).
  - AND, OR, NOR, XOR: bitwise.
  - SLL = src2<<sh; SRL = src2>>sh; SRA = arithmetic right shift of src2 by sh.
  - ROR = rotate src2 right by sh; sh=0 yields src2 unchanged.
  - SEQ, SLT (signed), SLTU (unsigned): 1 or 0, zero-extended.
  - Undefined op code: result 0; tag is still delivered.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- When defined, adds outputs perf_issued (32) and perf_stall (32), both reset to 0 by rst and not cleared by flush.
  - perf_issued increments on every grant.
  - perf_stall increments on every cycle with out_valid && !out_ready.
  - Both saturate at 32'hFFFF_FFFF.
- When undefined: ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset:
   - Stimulus: rst=1 for 2 cycles with all req_valid=4'b1111.
   - Required: req_ready=0, out_valid=0, out_result=0.
   - After release, first grant goes to requester 0.
2. Round-robin:
   - Stimulus: req_valid=4'b1111 held, out_ready=1.
   - Required: grants in order 0,1,2,3,0 on consecutive cycles.
   - out_valid stays 1 from cycle 2 on; out_src trails the grant by 1 cycle.
3. Stall:
   - Stimulus: req 2 issues ADD 5+7 tag 3, out_ready=0 for 3 cycles.
   - Required: out_result=12, out_tag=3, out_src=2 held stable, req_ready=0 throughout.
   - On out_ready=1 the next grant occurs in the same cycle.
4. ALU corners:
   - SUB 0-1 -> 32'hFFFF_FFFF.
   - SRA src2=32'h8000_0000, src1=31 -> 32'hFFFF_FFFF.
   - ROR src2=32'h1234_5678, src1=0 -> 32'h1234_5678.
   - ROR by 4 -> 32'h8123_4567.
   - SLT -1<1 -> 1; SLTU -> 0.
5. Flush:
   - Stimulus: out_valid=1, out_ready=0, req 1 valid, flush=1 for 1 cycle.
   - Required: next cycle out_valid=0, req 1 not consumed during flush, rr_ptr unchanged.
   - req 1 is granted the cycle after.
6. Perf (ALU_ARB_PERF_EN):
   - Stimulus: 3 grants then 2 stall cycles.
   - Required: perf_issued=3, perf_stall=2; rst clears both.

Source files
------------

// File: rtl/ex_alu_arbiter.sv
// ex_alu_arbiter: shares one integer ALU among NREQ issue requesters.
// A round-robin arbiter picks one valid requester per cycle. The ALU computes
// its op combinationally, and the result, tag and source index are registered
// into a single output slot. The slot is offered to the CDB over valid/ready.
// Optional build macro: ALU_ARB_PERF_EN adds the perf_issued and perf_stall
// saturating event counters.
module ex_alu_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int TAG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*OP_W-1:0]      req_op,
    input  logic [NREQ*DATA_W-1:0]    req_src1,
    input  logic [NREQ*DATA_W-1:0]    req_src2,
    input  logic [NREQ*TAG_W-1:0]     req_tag,
    output logic [NREQ-1:0]           req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_result,
    output logic [TAG_W-1:0]          out_tag,
    output logic [$clog2(NREQ)-1:0]   out_src
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]               perf_issued,
    output logic [31:0]               perf_stall
`endif
);

    localparam int SRC_W = $clog2(NREQ);

    localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] ALU_ADDU = OP_W'(1);
    localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] ALU_SUBU = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_AND  = OP_W'(4);
    localparam logic [OP_W-1:0] ALU_OR   = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_NOR  = OP_W'(6);
    localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(7);
    localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(8);
    localparam logic [OP_W-1:0] ALU_SRL  = OP_W'(9);
    localparam logic [OP_W-1:0] ALU_SRA  = OP_W'(10);
    localparam logic [OP_W-1:0] ALU_ROR  = OP_W'(11);
    localparam logic [OP_W-1:0] ALU_SEQ  = OP_W'(12);
    localparam logic [OP_W-1:0] ALU_SLT  = OP_W'(13);
    localparam logic [OP_W-1:0] ALU_SLTU = OP_W'(14);

    logic [SRC_W-1:0]  rrPtr_q;
    logic              outValid_q;
    logic [DATA_W-1:0] outResult_q;
    logic [TAG_W-1:0]  outTag_q;
    logic [SRC_W-1:0]  outSrc_q;

    logic              accept;
    logic              anyValid;
    logic              grantEn;
    logic [SRC_W-1:0]  grantIdx;
    logic [SRC_W:0]    candSum;
    logic [SRC_W-1:0]  cand;
    logic [SRC_W-1:0]  rrPtr_d;

    logic [OP_W-1:0]   gOp;
    logic [DATA_W-1:0] gSrc1;
    logic [DATA_W-1:0] gSrc2;
    logic [TAG_W-1:0]  gTag;
    logic [4:0]        sh;
    logic [DATA_W-1:0] aluResult;

    assign accept = !outValid_q || out_ready;

    // Cyclic search from rrPtr_q; walking the offsets from last to first lets the earliest valid one win.
    always_comb begin
        anyValid = 1'b0;
        grantIdx = '0;
        candSum  = '0;
        cand     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            candSum = {1'b0, rrPtr_q} + (SRC_W + 1)'(k);
            if (candSum >= (SRC_W + 1)'(NREQ)) begin
                candSum = candSum - (SRC_W + 1)'(NREQ);
            end
            cand = candSum[SRC_W-1:0];
            if (req_valid[cand]) begin
                anyValid = 1'b1;
                grantIdx = cand;
            end
        end
    end

    assign grantEn = anyValid && accept && !flush && !rst;
    assign rrPtr_d = (grantIdx == SRC_W'(NREQ - 1)) ? '0 : grantIdx + 1'b1;

    // One-hot grant, suppressed whenever the slot cannot take a new result.
    always_comb begin
        req_ready = '0;
        if (grantEn) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    assign gOp   = req_op[grantIdx*OP_W +: OP_W];
    assign gSrc1 = req_src1[grantIdx*DATA_W +: DATA_W];
    assign gSrc2 = req_src2[grantIdx*DATA_W +: DATA_W];
    assign gTag  = req_tag[grantIdx*TAG_W +: TAG_W];
    assign sh    = gSrc1[4:0];

    // Integer ALU on the granted operands; unknown op codes produce zero.
    always_comb begin
        aluResult = '0;
        case (gOp)
            ALU_ADD, ALU_ADDU: aluResult = gSrc1 + gSrc2;
            ALU_SUB, ALU_SUBU: aluResult = gSrc1 - gSrc2;
            ALU_AND:  aluResult = gSrc1 & gSrc2;
            ALU_OR:   aluResult = gSrc1 | gSrc2;
            ALU_NOR:  aluResult = ~(gSrc1 | gSrc2);
            ALU_XOR:  aluResult = gSrc1 ^ gSrc2;
            ALU_SLL:  aluResult = gSrc2 << sh;
            ALU_SRL:  aluResult = gSrc2 >> sh;
            ALU_SRA:  aluResult = $signed(gSrc2) >>> sh;
            ALU_ROR:  aluResult = (sh == 5'd0) ? gSrc2
                                  : ((gSrc2 >> sh) | (gSrc2 << (DATA_W - int'(sh))));
            ALU_SEQ:  aluResult = DATA_W'(gSrc1 == gSrc2);
            ALU_SLT:  aluResult = DATA_W'($signed(gSrc1) < $signed(gSrc2));
            ALU_SLTU: aluResult = DATA_W'(gSrc1 < gSrc2);
            default:  aluResult = '0;
        endcase
    end

    // Output slot and round-robin pointer: flush drops the slot, a grant reloads it, a handshake drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outResult_q <= '0;
            outTag_q    <= '0;
            outSrc_q    <= '0;
            rrPtr_q     <= '0;
        end else if (flush) begin
            outValid_q  <= 1'b0;
        end else if (grantEn) begin
            outValid_q  <= 1'b1;
            outResult_q <= aluResult;
            outTag_q    <= gTag;
            outSrc_q    <= grantIdx;
            rrPtr_q     <= rrPtr_d;
        end else if (outValid_q && out_ready) begin
            outValid_q  <= 1'b0;
        end
    end

    assign out_valid  = outValid_q;
    assign out_result = outResult_q;
    assign out_tag    = outTag_q;
    assign out_src    = outSrc_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perfIssued_q;
    logic [31:0] perfStall_q;

    // Saturating counts of grants and CDB back-pressure cycles; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            perfIssued_q <= '0;
            perfStall_q  <= '0;
        end else begin
            if (grantEn && perfIssued_q != 32'hFFFF_FFFF) begin
                perfIssued_q <= perfIssued_q + 32'd1;
            end
            if (outValid_q && !out_ready && perfStall_q != 32'hFFFF_FFFF) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign perf_issued = perfIssued_q;
    assign perf_stall  = perfStall_q;
`else
    // Without the perf build there are no counters and no extra ports.
`endif

endmodule
